// File: rtl/mux_pipe_pkg.sv
// Shared definitions for the N-to-1 select point with skid buffer:
// occupancy state encoding and the zero-fill constant used for out-of-range selectors.
package mux_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // Wide enough for any practical data width; users slice the low NBits.
  localparam int MAX_NBITS = 1024;
  localparam logic [MAX_NBITS-1:0] ZERO_FILL = '0;

endpackage

// File: rtl/mux_n_to_1.sv
// Purely combinational NBits x NInputs selector.
// Any selector value at or beyond NInputs yields all-zero data.
module mux_n_to_1
  import mux_pipe_pkg::*;
#(
  parameter int NBits   = 32,
  parameter int NInputs = 4,
  localparam int SelBits = $clog2(NInputs)
) (
  input  logic [SelBits-1:0]       Selector_i,
  input  logic [NInputs*NBits-1:0] Mux_Data_i,
  output logic [NBits-1:0]         Mux_Output_o
);

  always_comb begin
    Mux_Output_o = ZERO_FILL[NBits-1:0];
    for (int k = 0; k < NInputs; k++) begin
      if (Selector_i == SelBits'(k)) begin
        Mux_Output_o = Mux_Data_i[k*NBits +: NBits];
      end
    end
  end

endmodule

// File: rtl/mux_n_to_1_skid.sv
// N-to-1 multiplexer with registered output and a two-entry valid/ready skid buffer.
// Optional sticky out-of-range selector flag Sel_Err_o: define MUX_N_TO_1_SKID_SEL_ERR_EN.
module mux_n_to_1_skid
  import mux_pipe_pkg::*;
#(
  parameter int NBits   = 32,
  parameter int NInputs = 4,
  localparam int SelBits = $clog2(NInputs)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     Flush_i,
  input  logic                     Valid_i,
  output logic                     Ready_o,
  input  logic [SelBits-1:0]       Selector_i,
  input  logic [NInputs*NBits-1:0] Mux_Data_i,
  output logic                     Valid_o,
  input  logic                     Ready_i,
  output logic [NBits-1:0]         Mux_Output_o,
  output logic [SelBits-1:0]       Sel_o
`ifdef MUX_N_TO_1_SKID_SEL_ERR_EN
  ,
  output logic                     Sel_Err_o
`endif
);

  state_e               state_q, state_d;
  logic [NBits-1:0]     outData_q, outData_d;
  logic [SelBits-1:0]   outSel_q, outSel_d;
  logic [NBits-1:0]     skidData_q, skidData_d;
  logic [SelBits-1:0]   skidSel_q, skidSel_d;
  logic [NBits-1:0]     selData;
  logic                 accept;
  logic                 consume;

  mux_n_to_1 #(
    .NBits   (NBits),
    .NInputs (NInputs)
  ) u_mux (
    .Selector_i   (Selector_i),
    .Mux_Data_i   (Mux_Data_i),
    .Mux_Output_o (selData)
  );

  // Handshake flags come straight from the state register so Ready_i never reaches Ready_o.
  assign Ready_o = (state_q != ST_FULL);
  assign Valid_o = (state_q == ST_ONE) || (state_q == ST_FULL);
  assign accept  = Valid_i & Ready_o;
  assign consume = Valid_o & Ready_i;

  assign Mux_Output_o = outData_q;
  assign Sel_o        = outSel_q;

  always_comb begin
    state_d    = state_q;
    outData_d  = outData_q;
    outSel_d   = outSel_q;
    skidData_d = skidData_q;
    skidSel_d  = skidSel_q;
    if (Flush_i) begin
      state_d   = ST_EMPTY;
      outData_d = '0;
      outSel_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            outData_d = selData;
            outSel_d  = Selector_i;
            state_d   = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            outData_d = selData;
            outSel_d  = Selector_i;
          end else if (accept) begin
            skidData_d = selData;
            skidSel_d  = Selector_i;
            state_d    = ST_FULL;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (consume) begin
            outData_d = skidData_q;
            outSel_d  = skidSel_q;
            state_d   = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      outData_q  <= '0;
      outSel_q   <= '0;
      skidData_q <= '0;
      skidSel_q  <= '0;
    end else begin
      state_q    <= state_d;
      outData_q  <= outData_d;
      outSel_q   <= outSel_d;
      skidData_q <= skidData_d;
      skidSel_q  <= skidSel_d;
    end
  end

`ifdef MUX_N_TO_1_SKID_SEL_ERR_EN
  logic selInRange;
  logic selErr_q;

  assign selInRange = ({1'b0, Selector_i} < (SelBits+1)'(NInputs));
  assign Sel_Err_o  = selErr_q;

  // Sticky: only reset clears it, flush deliberately leaves it set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      selErr_q <= 1'b0;
    end else if (accept && !selInRange) begin
      selErr_q <= 1'b1;
    end
  end
`endif

endmodule
